// File: rtl/bcd_convert_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_convert_ctrl
//  Description : Sequential binary-to-BCD converter (double-dabble, shift and
//                add-3). One binary word is accepted on a valid/ready input
//                handshake and converted over binWidth cycles. The packed BCD
//                result is presented on a valid/ready output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_convert_ctrl #(
  parameter int binWidth  = 8,
  parameter int numDigits = 3
) (
  input  logic                   clk,
  input  logic                   rst,       // asynchronous, active-low
  input  logic [binWidth-1:0]    binIn,
  input  logic                   inValid,
  output logic                   inReady,
  output logic [4*numDigits-1:0] bcdOut,
  output logic                   outValid,
  input  logic                   outReady,
  output logic                   busy
);

  localparam int c_bcdWidth = 4 * numDigits;
  localparam int c_cntWidth = (binWidth < 2) ? 1 : $clog2(binWidth + 1);

  // The top digit can only stay within 0..9 if the digit count covers the
  // full binary range; refuse to elaborate otherwise.
  generate
    if ((10 ** numDigits) <= ((2 ** binWidth) - 1)) begin : g_paramCheck
      $error("bcd_convert_ctrl: numDigits=%0d too small for binWidth=%0d", numDigits, binWidth);
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                  r_state;
  logic [binWidth-1:0]     r_bin;
  logic [c_bcdWidth-1:0]   r_bcd;
  logic [c_cntWidth-1:0]   r_cnt;
  logic                    r_inReady;
  logic                    r_outValid;
  logic                    r_busy;
  logic [c_bcdWidth-1:0]   w_adj;

  // Add-3 correction applied independently to every digit; no inter-digit carry.
  generate
    for (genvar d = 0; d < numDigits; d++) begin : g_digit
      assign w_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? (r_bcd[4*d +: 4] + 4'd3)
                                                         : r_bcd[4*d +: 4];
    end
  endgenerate

  // Control FSM plus datapath: load, shift/add-3 iterations, output hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (inValid && r_inReady) begin
            r_bin     <= binIn;
            r_bcd     <= '0;
            r_cnt     <= c_cntWidth'(binWidth);
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          // Corrected digits shift up one place, bin MSB feeds the units LSB.
          r_bcd <= {w_adj[c_bcdWidth-2:0], r_bin[binWidth-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_cntWidth'(1)) begin
            r_busy     <= 1'b0;
            r_outValid <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          // Input reopens only on the cycle after the output handshake.
          if (r_outValid && outReady) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign inReady  = r_inReady;
  assign outValid = r_outValid;
  assign busy     = r_busy;
  assign bcdOut   = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_convert_ctrl
//  Description : Directed self-checking bench for bcd_convert_ctrl at
//                binWidth 8/3 digits, 4/2 digits and 1/1 digit.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bcd_convert_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [7:0]  binIn8 = '0;
  logic        inValid8 = 1'b0, inReady8, outValid8, outReady8 = 1'b0, busy8;
  logic [11:0] bcdOut8;

  logic [3:0]  binIn4 = '0;
  logic        inValid4 = 1'b0, inReady4, outValid4, outReady4 = 1'b0, busy4;
  logic [7:0]  bcdOut4;

  logic [0:0]  binIn1 = '0;
  logic        inValid1 = 1'b0, inReady1, outValid1, outReady1 = 1'b0, busy1;
  logic [3:0]  bcdOut1;

  int total = 0;
  int bad   = 0;

  bcd_convert_ctrl #(.binWidth(8), .numDigits(3)) dut8 (
    .clk(clk), .rst(rst), .binIn(binIn8), .inValid(inValid8), .inReady(inReady8),
    .bcdOut(bcdOut8), .outValid(outValid8), .outReady(outReady8), .busy(busy8));

  bcd_convert_ctrl #(.binWidth(4), .numDigits(2)) dut4 (
    .clk(clk), .rst(rst), .binIn(binIn4), .inValid(inValid4), .inReady(inReady4),
    .bcdOut(bcdOut4), .outValid(outValid4), .outReady(outReady4), .busy(busy4));

  bcd_convert_ctrl #(.binWidth(1), .numDigits(1)) dut1 (
    .clk(clk), .rst(rst), .binIn(binIn1), .inValid(inValid1), .inReady(inReady1),
    .bcdOut(bcdOut1), .outValid(outValid1), .outReady(outReady1), .busy(busy1));

  always #5 clk = ~clk;

  function automatic bit selInReady(input int sel);
    case (sel)
      8:       return inReady8;
      4:       return inReady4;
      default: return inReady1;
    endcase
  endfunction

  function automatic bit selOutValid(input int sel);
    case (sel)
      8:       return outValid8;
      4:       return outValid4;
      default: return outValid1;
    endcase
  endfunction

  function automatic logic [11:0] selBcd(input int sel);
    case (sel)
      8:       return bcdOut8;
      4:       return {4'h0, bcdOut4};
      default: return {8'h00, bcdOut1};
    endcase
  endfunction

  task automatic setIn(input int sel, input logic [7:0] v, input logic vld);
    case (sel)
      8:       begin binIn8 = v;      inValid8 = vld; end
      4:       begin binIn4 = v[3:0]; inValid4 = vld; end
      default: begin binIn1 = v[0];   inValid1 = vld; end
    endcase
  endtask

  task automatic setOutReady(input int sel, input logic r);
    case (sel)
      8:       outReady8 = r;
      4:       outReady4 = r;
      default: outReady1 = r;
    endcase
  endtask

  // Reference decimal encoding computed arithmetically.
  function automatic logic [11:0] refBcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One conversion: handshake in, count cycles to outValid, optionally accept.
  task automatic convert(input int sel, input logic [7:0] v, input bit doRelease,
                         output logic [11:0] res, output int lat, output bit timeout);
    int w;
    timeout = 1'b0;
    lat = 0;
    w = 0;
    while (!selInReady(sel) && w < 50) begin @(posedge clk); #1; w++; end
    if (!selInReady(sel)) timeout = 1'b1;
    setIn(sel, v, 1'b1);
    @(posedge clk); #1;
    setIn(sel, v, 1'b0);
    while (!selOutValid(sel) && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!selOutValid(sel)) timeout = 1'b1;
    res = selBcd(sel);
    if (doRelease) begin
      setOutReady(sel, 1'b1);
      @(posedge clk); #1;
      setOutReady(sel, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({inReady8, outValid8, busy8} !== 3'b100 || bcdOut8 !== 12'h000) begin
      bad++;
      $display("FAIL reset8: inReady/outValid/busy=%b bcdOut=%h, need 100 000", {inReady8, outValid8, busy8}, bcdOut8);
    end
    total++;
    if ({inReady4, outValid4, busy4} !== 3'b100 || bcdOut4 !== 8'h00) begin
      bad++;
      $display("FAIL reset4: inReady/outValid/busy=%b bcdOut=%h, need 100 00", {inReady4, outValid4, busy4}, bcdOut4);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0]  vals [4] = '{8'd255, 8'd0, 8'd99, 8'd100};
    logic [11:0] exps [4] = '{12'h255, 12'h000, 12'h099, 12'h100};
    logic [11:0] res;
    int lat;
    bit to;
    for (int i = 0; i < 4; i++) begin
      convert(8, vals[i], 1'b1, res, lat, to);
      total++;
      if (to || res !== exps[i] || lat != 8) begin
        bad++;
        $display("FAIL basic[%0d]: bcdOut=%h lat=%0d timeout=%0b, need %h lat=8", i, res, lat, to, exps[i]);
      end
      total++;
      if (inReady8 !== 1'b1 || outValid8 !== 1'b0) begin
        bad++;
        $display("FAIL basicRelease[%0d]: inReady=%b outValid=%b, need 1 0", i, inReady8, outValid8);
      end
    end
    // busy/inReady while converting
    setIn(8, 8'd7, 1'b1);
    @(posedge clk); #1;
    setIn(8, 8'd7, 1'b0);
    total++;
    if (busy8 !== 1'b1 || inReady8 !== 1'b0) begin
      bad++;
      $display("FAIL busyConvert: busy=%b inReady=%b, need 1 0", busy8, inReady8);
    end
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (outValid8 !== 1'b1 || busy8 !== 1'b0 || bcdOut8 !== 12'h007) begin
      bad++;
      $display("FAIL doneState: outValid=%b busy=%b bcdOut=%h, need 1 0 007", outValid8, busy8, bcdOut8);
    end
    outReady8 = 1'b1;
    @(posedge clk); #1;
    outReady8 = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [11:0] res;
    int lat;
    bit to;
    convert(8, 8'd128, 1'b0, res, lat, to);
    total++;
    if (to || res !== 12'h128) begin
      bad++;
      $display("FAIL bp128: bcdOut=%h timeout=%0b, need 128", res, to);
    end
    setIn(8, 8'd3, 1'b1);  // must be ignored in DONE
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (outValid8 !== 1'b1 || bcdOut8 !== 12'h128 || inReady8 !== 1'b0) begin
        bad++;
        $display("FAIL bpHold[%0d]: outValid=%b bcdOut=%h inReady=%b, need 1 128 0", i, outValid8, bcdOut8, inReady8);
      end
    end
    setIn(8, 8'd3, 1'b0);
    outReady8 = 1'b1;
    @(posedge clk); #1;
    outReady8 = 1'b0;
    total++;
    if (inReady8 !== 1'b1 || outValid8 !== 1'b0 || busy8 !== 1'b0) begin
      bad++;
      $display("FAIL bpRelease: inReady=%b outValid=%b busy=%b, need 1 0 0", inReady8, outValid8, busy8);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int c1 = -1, c2 = -1;
    logic [11:0] r1 = '0, r2 = '0;
    bit secondSet = 1'b0;
    outReady8 = 1'b1;
    setIn(8, 8'd42, 1'b1);
    @(posedge clk); #1;
    while (n < 40) begin
      if (!secondSet && inReady8) begin
        binIn8 = 8'd73;
        secondSet = 1'b1;
      end else if (!secondSet) begin
        binIn8 = 8'(n * 37 + 11);
      end else if (!inReady8) begin
        inValid8 = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      if (outValid8 && c1 < 0) begin c1 = n; r1 = bcdOut8; end
      else if (outValid8 && c2 < 0) begin c2 = n; r2 = bcdOut8; end
    end
    inValid8 = 1'b0;
    outReady8 = 1'b0;
    total++;
    if (c1 != 8 || r1 !== 12'h042) begin
      bad++;
      $display("FAIL b2bFirst: outValid at %0d bcdOut=%h, need 8 042", c1, r1);
    end
    total++;
    if (c2 - c1 != 10 || r2 !== 12'h073) begin
      bad++;
      $display("FAIL b2bSecond: spacing=%0d bcdOut=%h, need 10 073", c2 - c1, r2);
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] res;
    int lat;
    bit to;
    setIn(8, 8'd200, 1'b1);
    @(posedge clk); #1;
    setIn(8, 8'd200, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (busy8 !== 1'b1) begin
      bad++;
      $display("FAIL preReset: busy=%b, need 1", busy8);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({inReady8, outValid8, busy8} !== 3'b100 || bcdOut8 !== 12'h000) begin
      bad++;
      $display("FAIL asyncReset: inReady/outValid/busy=%b bcdOut=%h, need 100 000", {inReady8, outValid8, busy8}, bcdOut8);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    convert(8, 8'd37, 1'b1, res, lat, to);
    total++;
    if (to || res !== 12'h037 || lat != 8) begin
      bad++;
      $display("FAIL postReset37: bcdOut=%h lat=%0d timeout=%0b, need 037 lat=8", res, lat, to);
    end
  endtask

  task automatic test_small_width();
    logic [11:0] res;
    int lat;
    bit to;
    convert(4, 8'd15, 1'b1, res, lat, to);
    total++;
    if (to || res !== 12'h015 || lat != 4) begin
      bad++;
      $display("FAIL w4_15: bcdOut=%h lat=%0d timeout=%0b, need 15 lat=4", res, lat, to);
    end
    convert(4, 8'd9, 1'b1, res, lat, to);
    total++;
    if (to || res !== 12'h009 || lat != 4) begin
      bad++;
      $display("FAIL w4_9: bcdOut=%h lat=%0d timeout=%0b, need 09 lat=4", res, lat, to);
    end
    convert(1, 8'd1, 1'b1, res, lat, to);
    total++;
    if (to || res !== 12'h001 || lat != 1) begin
      bad++;
      $display("FAIL w1_1: bcdOut=%h lat=%0d timeout=%0b, need 1 lat=1", res, lat, to);
    end
    convert(1, 8'd0, 1'b1, res, lat, to);
    total++;
    if (to || res !== 12'h000 || lat != 1) begin
      bad++;
      $display("FAIL w1_0: bcdOut=%h lat=%0d timeout=%0b, need 0 lat=1", res, lat, to);
    end
  endtask

  task automatic test_exhaustive();
    logic [11:0] res;
    int lat;
    bit to;
    for (int v = 0; v < 256; v++) begin
      convert(8, 8'(v), 1'b1, res, lat, to);
      total++;
      if (to || res !== refBcd(v)) begin
        bad++;
        $display("FAIL exh[%0d]: bcdOut=%h timeout=%0b, need %h", v, res, to, refBcd(v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_small_width();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
